// File: rtl/alu_issue_stage.sv
// ID/EX issue register with MEM/WB operand forwarding, load-use bubble insertion
// and flush. Feeds op_a/op_b/ctrl to the EX-stage ALU.
module alu_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [REG_AW-1:0]  id_rs_addr,
    input  logic [REG_AW-1:0]  id_rt_addr,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [SHAMT_W-1:0] id_shamt,
    input  logic               id_src_a_sel,
    input  logic               id_src_b_sel,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [3:0]         id_alu_ctrl,
    input  logic [REG_AW-1:0]  id_rd_addr,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               flush,
    input  logic               ex_ready,
    input  logic               mem_fwd_en,
    input  logic [REG_AW-1:0]  mem_rd_addr,
    input  logic [DATA_W-1:0]  mem_result,
    input  logic               wb_reg_write,
    input  logic [REG_AW-1:0]  wb_rd_addr,
    input  logic [DATA_W-1:0]  wb_result,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_op_a,
    output logic [DATA_W-1:0]  ex_op_b,
    output logic [3:0]         ex_ctrl,
    output logic [REG_AW-1:0]  ex_rd_addr,
    output logic               ex_reg_write,
    output logic               ex_mem_read
);

    typedef struct packed {
        logic [REG_AW-1:0]  rs_addr;
        logic [REG_AW-1:0]  rt_addr;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
        logic [SHAMT_W-1:0] shamt;
        logic               src_a_sel;
        logic               src_b_sel;
        logic [3:0]         alu_ctrl;
        logic [REG_AW-1:0]  rd_addr;
        logic               reg_write;
        logic               mem_read;
    } issue_t;

    issue_t q;
    logic   vld;
    logic   load_use, advance, xfer;
    logic   mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    assign load_use = vld && q.mem_read && (q.rd_addr != '0) &&
                      ((id_uses_rs && (id_rs_addr == q.rd_addr)) ||
                       (id_uses_rt && (id_rt_addr == q.rd_addr)));
    assign advance  = !vld || ex_ready;
    assign id_ready = rst_n && advance && !load_use;
    assign xfer     = id_valid && id_ready;

    // Register 0 is hardwired zero, so it never matches as a forward source.
    assign mem_hit_a = mem_fwd_en && (mem_rd_addr != '0) && (mem_rd_addr == q.rs_addr);
    assign mem_hit_b = mem_fwd_en && (mem_rd_addr != '0) && (mem_rd_addr == q.rt_addr);
    assign wb_hit_a  = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == q.rs_addr);
    assign wb_hit_b  = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == q.rt_addr);

    always_comb begin
        fwd_a = q.rs_data;
        fwd_b = q.rt_data;
        if (mem_hit_a)     fwd_a = mem_result;
        else if (wb_hit_a) fwd_a = wb_result;
        if (mem_hit_b)     fwd_b = mem_result;
        else if (wb_hit_b) fwd_b = wb_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            q   <= '0;
        end else begin
            if (flush)        vld <= 1'b0;
            else if (advance) vld <= xfer;

            if (xfer && !flush) begin
                q.rs_addr   <= id_rs_addr;
                q.rt_addr   <= id_rt_addr;
                q.rs_data   <= id_rs_data;
                q.rt_data   <= id_rt_data;
                q.imm       <= id_imm;
                q.shamt     <= id_shamt;
                q.src_a_sel <= id_src_a_sel;
                q.src_b_sel <= id_src_b_sel;
                q.alu_ctrl  <= id_alu_ctrl;
                q.rd_addr   <= id_rd_addr;
                q.reg_write <= id_reg_write;
                q.mem_read  <= id_mem_read;
            end else begin
                // WB results leave the pipe after one cycle; absorb them so a
                // long stall cannot strand stale register data.
                if (wb_hit_a) q.rs_data <= wb_result;
                if (wb_hit_b) q.rt_data <= wb_result;
            end
        end
    end

    assign ex_valid     = vld;
    assign ex_op_a      = q.src_a_sel ? {{(DATA_W-SHAMT_W){1'b0}}, q.shamt} : fwd_a;
    assign ex_op_b      = q.src_b_sel ? q.imm : fwd_b;
    assign ex_ctrl      = q.alu_ctrl;
    assign ex_rd_addr   = q.rd_addr;
    assign ex_reg_write = vld && q.reg_write;
    assign ex_mem_read  = vld && q.mem_read;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX pipeline register and operand-forwarding stage that feeds the EX-stage arithmetic unit. It captures decoded instructions from ID under a valid/ready handshake and resolves RAW hazards by forwarding from MEM and WB. It detects load-use hazards and inserts bubbles. It presents final op_a/op_b/ctrl to the ALU, using the same 4-bit ctrl encoding the ALU decodes.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width
SHAMT_W, 5, shift-amount field width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID presents an instruction
id_ready  out  1  stage accepts the ID instruction this cycle
id_rs_addr  in  REG_AW  source A register
id_rt_addr  in  REG_AW  source B register
id_rs_data  in  DATA_W  regfile read A
id_rt_data  in  DATA_W  regfile read B
id_imm  in  DATA_W  extended immediate
id_shamt  in  SHAMT_W  shift amount field
id_src_a_sel  in  1  0=rs, 1=zero-extended shamt
id_src_b_sel  in  1  0=rt, 1=imm
id_uses_rs, id_uses_rt  in  1 each  operand is actually read
id_alu_ctrl  in  4  ALU opcode
id_rd_addr  in  REG_AW  destination register
id_reg_write, id_mem_read  in  1 each  writeback enable, load flag
flush  in  1  squash the held instruction (branch/exception)
ex_ready  in  1  downstream accepts the EX instruction
mem_fwd_en  in  1  MEM result valid for forwarding (never for loads)
mem_rd_addr, mem_result  in  REG_AW, DATA_W  MEM-stage forward source
wb_reg_write  in  1  WB writes the regfile
wb_rd_addr, wb_result  in  REG_AW, DATA_W  WB-stage forward source
ex_valid  out  1  op_a/op_b/ctrl are meaningful
ex_op_a, ex_op_b  out  DATA_W  ALU operands
ex_ctrl  out  4  ALU opcode
ex_rd_addr  out  REG_AW  destination
ex_reg_write, ex_mem_read  out  1 each  propagated control

Behaviour:
- Reset (async, rst_n=0): all registered state and every output cleared to 0, including ex_valid=0 and ex_ctrl=4'b0000. id_ready evaluates to 1 once rst_n=1.
- load_use = ex_valid & ex_mem_read & (ex_rd_addr!=0) & ((id_uses_rs & id_rs_addr==ex_rd_addr) | (id_uses_rt & id_rt_addr==ex_rd_addr)).
- id_ready = (!ex_valid | ex_ready) & !load_use. It is combinational.
- Transfer occurs on a rising edge when id_valid & id_ready. The stage captures all id_* fields and sets ex_valid=1.
- On a rising edge with advance (!ex_valid | ex_ready) and no transfer: ex_valid<=0. This is a bubble, and load_use forces this path.
- Stall (ex_valid & !ex_ready): all fields are held.
- Operand refresh while held: if wb_reg_write & wb_rd_addr!=0 & wb_rd_addr matches a stored rs/rt address, the stored data is overwritten with wb_result. Stale data is never lost across a long stall.
- flush has priority over everything except reset. On an edge with flush=1, ex_valid<=0 regardless of ex_ready or incoming transfer. id_ready is unaffected; ID handles its own squash.
- Forwarding is combinational on stored rs/rt data, with per-operand priority:
  1. MEM, if mem_fwd_en & mem_rd_addr!=0 & match.
  2. WB, if wb_reg_write & wb_rd_addr!=0 & match.
  3. Stored data otherwise.
- Register 0 is never forwarded.
- ex_op_a = src_a_sel ? {zeros, shamt} : fwd_a.
- ex_op_b = src_b_sel ? imm : fwd_b.
- Forwarding into unused operands is harmless.
- Latency: one cycle from ID acceptance to ex_valid. The throughput is one instruction per cycle with no hazards.
- A load-use hazard costs exactly one bubble. The next cycle the load has moved to MEM, and WB or later forwarding resolves the dependency.
- When ex_valid=0, ex_op_a/ex_op_b/ex_ctrl may hold stale values. ex_reg_write and ex_mem_read must read 0.

Test Plan:
- Reset mid-stream: ex_valid=1 holding ctrl=4'b0011, assert rst_n=0 between edges -> all outputs 0 immediately, no clock needed.
- Back-to-back RAW: add r3 (MEM result 0x0000_0010 on r3) then sub using r3, WB also writing r3=0x5 -> ex_op_a=0x10 (MEM beats WB).
- Load-use: lw r4 in EX, next instruction reads r4 -> id_ready=0 for one cycle, ex_valid=0 next cycle, then accept with r4 forwarded from WB.
- Stall with refresh: ex_ready=0 for 3 cycles, WB writes r7=0xDEAD_BEEF matching stored rt -> after release ex_op_b=0xDEADBEEF even after WB moves on.
- Shift/immediate select: src_a_sel=1, shamt=5'd31, src_b_sel=1, imm=0xFFFF_8000 -> ex_op_a=0x1F, ex_op_b=0xFFFF8000.
- Flush vs transfer: flush=1 and id_valid=1 same edge -> ex_valid=0 next cycle, ex_reg_write=0; r0 as destination in MEM never forwards (ex_op_a=stored data).
